// File: rtl/seg7_scan_decoder_if.sv
// rtl/seg7_scan_decoder_if.sv - multiplexed 7-segment display bus plus decoded monitor outputs
interface seg7_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   digit_ok;
  logic [DIGITS-1:0]   blank;
  logic                bad_pattern;
  logic                an_error;
  logic                frame_done;

  modport master (
    output seg_n, an_n,
    input  value, digit_ok, blank, bad_pattern, an_error, frame_done
  );

  modport slave (
    input  seg_n, an_n,
    output value, digit_ok, blank, bad_pattern, an_error, frame_done
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - reconstructs hex digits from an active-low multiplexed 7-segment bus
module seg7_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input logic                clk,
  input logic                rst_n,
  seg7_scan_decoder_if.slave bus
);
  localparam int SW = DIGITS + 7;
  localparam int CW = $clog2(STABLE + 1);

  logic [6:0]          seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  logic [DIGITS-1:0]   an_s1_q, an_s1_d, an_s2_q, an_s2_d;
  logic [SW-1:0]       prev_q, prev_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   digit_ok_q, digit_ok_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                bad_q, bad_d;
  logic                an_err_q, an_err_d;
  logic                frame_done_q, frame_done_d;

  logic [SW-1:0]       samp;
  logic [DIGITS-1:0]   en;
  logic [DIGITS-1:0]   seen_next;
  logic                accept;
  logic                one_hot;
  logic                multi;
  logic [4:0]          dec;

  // Returns {legal, nibble}; blank and illegal patterns both report legal=0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001101: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    seg_s1_d     = bus.seg_n;
    seg_s2_d     = seg_s1_q;
    an_s1_d      = bus.an_n;
    an_s2_d      = an_s1_q;
    samp         = {an_s2_q, seg_s2_q};
    prev_d       = samp;
    value_d      = value_q;
    digit_ok_d   = digit_ok_q;
    blank_d      = blank_q;
    seen_d       = seen_q;
    bad_d        = 1'b0;
    an_err_d     = 1'b0;
    frame_done_d = 1'b0;

    if (samp == prev_q) begin
      cnt_d = (cnt_q == CW'(STABLE)) ? cnt_q : cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
    accept = (samp == prev_q) && (cnt_q == CW'(STABLE - 1));

    en      = ~an_s2_q;
    multi   = (en & (en - DIGITS'(1))) != '0;
    one_hot = (en != '0) && !multi;
    dec     = decode(seg_s2_q);
    seen_next = seen_q | en;

    if (accept && multi) begin
      an_err_d = 1'b1;
    end

    if (accept && one_hot) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (en[k]) begin
          if (dec[4]) begin
            value_d[4*k +: 4] = dec[3:0];
            digit_ok_d[k]     = 1'b1;
            blank_d[k]        = 1'b0;
          end else if (seg_s2_q == 7'h7F) begin
            digit_ok_d[k]     = 1'b0;
            blank_d[k]        = 1'b1;
          end else begin
            digit_ok_d[k]     = 1'b0;
            blank_d[k]        = 1'b0;
            bad_d             = 1'b1;
          end
        end
      end
      // The digit accepted on this edge counts towards completing the frame.
      if (seen_next == '1) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end else begin
        seen_d       = seen_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q     <= '1;
      seg_s2_q     <= '1;
      an_s1_q      <= '1;
      an_s2_q      <= '1;
      prev_q       <= '1;
      cnt_q        <= '0;
      seen_q       <= '0;
      value_q      <= '0;
      digit_ok_q   <= '0;
      blank_q      <= '0;
      bad_q        <= 1'b0;
      an_err_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      seg_s1_q     <= seg_s1_d;
      seg_s2_q     <= seg_s2_d;
      an_s1_q      <= an_s1_d;
      an_s2_q      <= an_s2_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      value_q      <= value_d;
      digit_ok_q   <= digit_ok_d;
      blank_q      <= blank_d;
      bad_q        <= bad_d;
      an_err_q     <= an_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.digit_ok    = digit_ok_q;
  assign bus.blank       = blank_q;
  assign bus.bad_pattern = bad_q;
  assign bus.an_error    = an_err_q;
  assign bus.frame_done  = frame_done_q;
endmodule
